// File: rtl/ureg_pkg.sv
// ureg_pkg: shift-register operating-mode codes and the counter-width helper.
package ureg_pkg;
    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_ROL  = 2'b11;
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating counter (clk, rst async, clear, en, inc -> count, hit pulse on reaching MAX).
module sat_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         hit
);
    localparam logic [W-1:0] MAXV = W'(MAX);
    logic step;
    assign step = !clear && en && inc && count != MAXV;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            hit   <= 1'b0;
        end else begin
            count <= clear ? '0 : step ? count + 1'b1 : count;
            hit   <= step && count == MAXV - 1'b1;
        end
    end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register (clk, reset async, set, en, mode, D, sin -> Q, sout, cnt, done).
module univ_shift_reg
    import ureg_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] SET_VALUE   = '1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic [CW-1:0]    cnt,
    output logic             done
);
    logic [WIDTH-1:0] nq;
    logic             ns;
    always_comb begin
        nq = mode == MODE_LOAD ? D :
             mode == MODE_SHL  ? {Q[WIDTH-2:0], sin} :
             mode == MODE_SHR  ? {sin, Q[WIDTH-1:1]} :
                                 {Q[WIDTH-2:0], Q[WIDTH-1]};
        ns = mode == MODE_LOAD ? sout :
             mode == MODE_SHR  ? Q[0] : Q[WIDTH-1];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Q    <= RESET_VALUE;
            sout <= 1'b0;
        end else if (set) begin
            Q    <= SET_VALUE;
        end else if (en) begin
            Q    <= nq;
            sout <= ns;
        end
    end
    sat_counter #(.MAX(WIDTH), .W(CW)) u_cnt (
        .clk  (clk),
        .rst  (reset),
        .clear(set || (en && mode == MODE_LOAD)),
        .en   (en),
        .inc  (mode != MODE_LOAD),
        .count(cnt),
        .hit  (done)
    );
endmodule
